// File: rtl/switch_debounce.sv
// Two-bit switch conditioner: double-flop synchroniser plus an independent
// debounce counter per bit, with registered per-bit and combined change pulses.
module switch_debounce #(
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_switch_raw,
    output logic [1:0] o_switch,
    output logic [1:0] o_change,
    output logic       o_any_change
);

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DB_CYCLES - 1);
    localparam logic             FLIP_NOW = (DB_CYCLES == 1);

    logic [1:0] r_s1;
    logic [1:0] r_s2;
    logic [1:0] w_flip;
    logic       r_anyChange;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 2'b00;
            r_s2 <= 2'b00;
        end else begin
            r_s1 <= i_switch_raw;
            r_s2 <= r_s1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_bit
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_switch;
        logic             r_change;
        logic             w_differ;

        assign w_differ  = r_s2[i] ^ r_switch;
        // A flip needs DB_CYCLES consecutive disagreeing samples; STABLE accounts for the first.
        assign w_flip[i] = w_differ & ((r_state == STABLE) ? FLIP_NOW : (r_cnt == LAST_CNT));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state  <= STABLE;
                r_cnt    <= '0;
                r_switch <= 1'b0;
                r_change <= 1'b0;
            end else begin
                r_change <= 1'b0;
                case (r_state)
                    STABLE: begin
                        if (w_flip[i]) begin
                            r_switch <= r_s2[i];
                            r_change <= 1'b1;
                        end else if (w_differ) begin
                            r_state <= COUNT;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    COUNT: begin
                        if (!w_differ) begin
                            r_state <= STABLE;
                            r_cnt   <= '0;
                        end else if (w_flip[i]) begin
                            r_switch <= r_s2[i];
                            r_change <= 1'b1;
                            r_state  <= STABLE;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign o_switch[i] = r_switch;
        assign o_change[i] = r_change;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anyChange <= 1'b0;
        end else begin
            r_anyChange <= |w_flip;
        end
    end

    assign o_any_change = r_anyChange;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DB_CYCLES=4: each flip is expected
// at the sixth edge after the raw level is first sampled.
module tb_switch_debounce;

    logic       clk;
    logic       rst_n;
    logic [1:0] switchRaw;
    logic [1:0] switchOut;
    logic [1:0] changeOut;
    logic       anyChange;

    int testsRun;
    int testsFailed;

    switch_debounce #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_switch_raw (switchRaw),
        .o_switch     (switchOut),
        .o_change     (changeOut),
        .o_any_change (anyChange)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        switchRaw = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        switchRaw = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (switchOut !== 2'b00 || changeOut !== 2'b00 || anyChange !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_async: switch=%b change=%b any=%b, wanted 00 00 0",
                     switchOut, changeOut, anyChange);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            testsRun++;
            if (switchOut !== 2'b00 || changeOut !== 2'b00 || anyChange !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_hold cycle %0d: switch=%b change=%b any=%b, wanted 00 00 0",
                         k, switchOut, changeOut, anyChange);
            end
        end
        switchRaw = 2'b00;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_glitch();
        doReset();
        switchRaw = 2'b01;
        tick();
        tick();
        tick();
        switchRaw = 2'b00;
        for (int k = 0; k < 10; k++) begin
            tick();
            testsRun++;
            if (switchOut !== 2'b00 || changeOut !== 2'b00 || anyChange !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL glitch cycle %0d: switch=%b change=%b any=%b, wanted 00 00 0",
                         k, switchOut, changeOut, anyChange);
            end
        end
    endtask

    task automatic test_min_pulse();
        logic [1:0] expSw;
        doReset();
        switchRaw = 2'b01;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 4) switchRaw = 2'b00;
            expSw = (e >= 6 && e <= 9) ? 2'b01 : 2'b00;
            testsRun++;
            if (switchOut !== expSw || changeOut !== ((e == 6 || e == 10) ? 2'b01 : 2'b00)) begin
                testsFailed++;
                $display("[TB] FAIL min_pulse edge %0d: switch=%b change=%b, wanted switch=%b",
                         e, switchOut, changeOut, expSw);
            end
        end
    endtask

    task automatic test_clean_step();
        doReset();
        switchRaw = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            testsRun++;
            if (e < 6) begin
                if (switchOut !== 2'b00 || changeOut !== 2'b00 || anyChange !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL clean_step_pre edge %0d: switch=%b change=%b any=%b, wanted 00 00 0",
                             e, switchOut, changeOut, anyChange);
                end
            end else if (e == 6) begin
                if (switchOut !== 2'b01 || changeOut !== 2'b01 || anyChange !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL clean_step_flip edge 6: switch=%b change=%b any=%b, wanted 01 01 1",
                             switchOut, changeOut, anyChange);
                end
            end else begin
                if (switchOut !== 2'b01 || changeOut !== 2'b00 || anyChange !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL clean_step_post edge %0d: switch=%b change=%b any=%b, wanted 01 00 0",
                             e, switchOut, changeOut, anyChange);
                end
            end
        end
    endtask

    task automatic test_bounce();
        // Starts from switch=01 left by the clean step.
        for (int k = 0; k < 12; k++) begin
            switchRaw = {~k[0], 1'b1};
            tick();
            testsRun++;
            if (switchOut !== 2'b01 || changeOut !== 2'b00 || anyChange !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL bounce cycle %0d: switch=%b change=%b any=%b, wanted 01 00 0",
                         k, switchOut, changeOut, anyChange);
            end
        end
        switchRaw = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            tick();
            testsRun++;
            if (e < 6) begin
                if (switchOut !== 2'b01 || changeOut !== 2'b00) begin
                    testsFailed++;
                    $display("[TB] FAIL bounce_settle edge %0d: switch=%b change=%b, wanted 01 00",
                             e, switchOut, changeOut);
                end
            end else if (e == 6) begin
                if (switchOut !== 2'b11 || changeOut !== 2'b10 || anyChange !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL bounce_flip edge 6: switch=%b change=%b any=%b, wanted 11 10 1",
                             switchOut, changeOut, anyChange);
                end
            end else begin
                if (switchOut !== 2'b11 || changeOut !== 2'b00 || anyChange !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL bounce_post edge 7: switch=%b change=%b any=%b, wanted 11 00 0",
                             switchOut, changeOut, anyChange);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        doReset();
        switchRaw = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            tick();
            testsRun++;
            if (e < 6) begin
                if (switchOut !== 2'b00 || changeOut !== 2'b00 || anyChange !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL simul_pre edge %0d: switch=%b change=%b any=%b, wanted 00 00 0",
                             e, switchOut, changeOut, anyChange);
                end
            end else if (e == 6) begin
                if (switchOut !== 2'b11 || changeOut !== 2'b11 || anyChange !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL simul_flip edge 6: switch=%b change=%b any=%b, wanted 11 11 1",
                             switchOut, changeOut, anyChange);
                end
            end else begin
                if (switchOut !== 2'b11 || changeOut !== 2'b00 || anyChange !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL simul_post edge 7: switch=%b change=%b any=%b, wanted 11 00 0",
                             switchOut, changeOut, anyChange);
                end
            end
        end
    endtask

    task automatic test_reset_mid_count();
        doReset();
        switchRaw = 2'b01;
        for (int e = 1; e <= 3; e++) begin
            tick();
            testsRun++;
            if (switchOut !== 2'b00 || changeOut !== 2'b00) begin
                testsFailed++;
                $display("[TB] FAIL midreset_pre edge %0d: switch=%b change=%b, wanted 00 00",
                         e, switchOut, changeOut);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        testsRun++;
        if (switchOut !== 2'b00 || changeOut !== 2'b00 || anyChange !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_held: switch=%b change=%b any=%b, wanted 00 00 0",
                     switchOut, changeOut, anyChange);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            testsRun++;
            if (e < 6) begin
                if (switchOut !== 2'b00 || changeOut !== 2'b00) begin
                    testsFailed++;
                    $display("[TB] FAIL midreset_recount edge %0d: switch=%b change=%b, wanted 00 00",
                             e, switchOut, changeOut);
                end
            end else if (e == 6) begin
                if (switchOut !== 2'b01 || changeOut !== 2'b01 || anyChange !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL midreset_flip edge 6: switch=%b change=%b any=%b, wanted 01 01 1",
                             switchOut, changeOut, anyChange);
                end
            end else begin
                if (switchOut !== 2'b01 || changeOut !== 2'b00) begin
                    testsFailed++;
                    $display("[TB] FAIL midreset_post edge 7: switch=%b change=%b, wanted 01 00",
                             switchOut, changeOut);
                end
            end
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b1;
        switchRaw   = 2'b00;
        tick();
        test_reset();
        test_glitch();
        test_min_pulse();
        test_clean_step();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
